// File: rtl/mem_arbiter.sv
// Arbiter sharing one external memory line port between icache fills and dcache fills/writebacks.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN; otherwise dcache wins ties.
//
// state  | meaning
// IDLE   | sample requests, latch winner into transaction registers
// BUSY   | memory request outstanding, wait for mem_ready_i
// DONE   | one-cycle valid pulse to the owning cache
module mem_arbiter #(
   parameter int ADDR_W = 20,
   parameter int LINE_W = 128
) (
   input  logic              clk_i,
   input  logic              rsn_i,
   input  logic              ic_req_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic              ic_valid_o,
   output logic [LINE_W-1:0] ic_data_o,
   input  logic              dc_req_i,
   input  logic              dc_we_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [LINE_W-1:0] dc_wdata_i,
   output logic              dc_valid_o,
   output logic [LINE_W-1:0] dc_data_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [LINE_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_owner;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_wdata;
   logic [LINE_W-1:0]   r_ic_data;
   logic [LINE_W-1:0]   r_dc_data;
   logic                w_start;
   logic                w_grant_dc;
   logic [ADDR_W-1:0]   w_addr_sel;

   assign w_start = ic_req_i | dc_req_i;

`ifdef MEM_ARB_RR_EN
   // r_last_dc: 0 = icache granted last, 1 = dcache granted last
   logic r_last_dc;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i)
         r_last_dc <= 1'b0;
      else if (r_state == S_IDLE && w_start)
         r_last_dc <= w_grant_dc;
   end

   assign w_grant_dc = dc_req_i & (~ic_req_i | ~r_last_dc);
`else
   assign w_grant_dc = dc_req_i;
`endif

   assign w_addr_sel = w_grant_dc ? dc_addr_i : ic_addr_i;

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (r_state == S_IDLE && w_start) begin
         r_owner <= w_grant_dc;
         r_we    <= w_grant_dc & dc_we_i;
         r_addr  <= {w_addr_sel[ADDR_W-1:4], 4'b0000};
         r_wdata <= w_grant_dc ? dc_wdata_i : '0;
      end
   end

   // Read data lands only in the owner's line register; writebacks leave both untouched
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         r_ic_data <= '0;
         r_dc_data <= '0;
      end else if (r_state == S_BUSY && mem_ready_i && !r_we) begin
         if (r_owner)
            r_dc_data <= mem_rdata_i;
         else
            r_ic_data <= mem_rdata_i;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      ic_valid_o  = 1'b0;
      dc_valid_o  = 1'b0;
      busy_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start)
               w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            mem_req_o = 1'b1;
            mem_we_o  = r_we;
            busy_o    = 1'b1;
            if (mem_ready_i)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            ic_valid_o  = ~r_owner;
            dc_valid_o  = r_owner;
            busy_o      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign ic_data_o   = r_ic_data;
   assign dc_data_o   = r_dc_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: fills, writeback, ties, zero-wait, reset abort, spurious ready.
// Tie expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arbiter;

   localparam int ADDR_W = 20;
   localparam int LINE_W = 128;

   logic              clk_i = 1'b0;
   logic              rsn_i;
   logic              ic_req_i;
   logic [ADDR_W-1:0] ic_addr_i;
   logic              ic_valid_o;
   logic [LINE_W-1:0] ic_data_o;
   logic              dc_req_i;
   logic              dc_we_i;
   logic [ADDR_W-1:0] dc_addr_i;
   logic [LINE_W-1:0] dc_wdata_i;
   logic              dc_valid_o;
   logic [LINE_W-1:0] dc_data_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [LINE_W-1:0] mem_wdata_o;
   logic              mem_ready_i;
   logic [LINE_W-1:0] mem_rdata_i;
   logic              busy_o;

   int checks = 0;
   int errors = 0;

   logic [LINE_W-1:0] exp_ic;
   logic [LINE_W-1:0] exp_dc;
   logic [LINE_W-1:0] line_v;
   logic              exp_win_dc;

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk_i       (clk_i),
      .rsn_i       (rsn_i),
      .ic_req_i    (ic_req_i),
      .ic_addr_i   (ic_addr_i),
      .ic_valid_o  (ic_valid_o),
      .ic_data_o   (ic_data_o),
      .dc_req_i    (dc_req_i),
      .dc_we_i     (dc_we_i),
      .dc_addr_i   (dc_addr_i),
      .dc_wdata_i  (dc_wdata_i),
      .dc_valid_o  (dc_valid_o),
      .dc_data_o   (dc_data_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ready_i (mem_ready_i),
      .mem_rdata_i (mem_rdata_i),
      .busy_o      (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rsn_i       = 1'b0;
      ic_req_i    = 1'b0;
      ic_addr_i   = '0;
      dc_req_i    = 1'b0;
      dc_we_i     = 1'b0;
      dc_addr_i   = '0;
      dc_wdata_i  = '0;
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      exp_ic      = '0;
      exp_dc      = '0;
      tick();
      tick();
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ic_valid", ic_valid_o, 0);
      chk("rst_dc_valid", dc_valid_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_ic_data", ic_data_o, 0);
      chk("rst_dc_data", dc_data_o, 0);
      rsn_i = 1'b1;
      tick();

      // IC fill, ready three cycles after mem_req_o rises
      ic_req_i  = 1'b1;
      ic_addr_i = 20'h12345;
      tick();
      chk("ic_mem_req", mem_req_o, 1);
      chk("ic_mem_addr", mem_addr_o, 20'h12340);
      chk("ic_mem_we", mem_we_o, 0);
      chk("ic_busy", busy_o, 1);
      tick();
      tick();
      chk("ic_wait_req", mem_req_o, 1);
      chk("ic_wait_valid", ic_valid_o, 0);
      line_v      = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      mem_ready_i = 1'b1;
      mem_rdata_i = line_v;
      tick();
      exp_ic      = line_v;
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      chk("ic_valid", ic_valid_o, 1);
      chk("ic_dc_valid", dc_valid_o, 0);
      chk("ic_data", ic_data_o, exp_ic);
      chk("ic_done_req", mem_req_o, 0);
      chk("ic_done_busy", busy_o, 1);
      ic_req_i = 1'b0;
      tick();
      chk("ic_idle_valid", ic_valid_o, 0);
      chk("ic_idle_busy", busy_o, 0);

      // DC writeback: read data on the bus must not be captured
      dc_req_i   = 1'b1;
      dc_we_i    = 1'b1;
      dc_addr_i  = 20'h0ABCD;
      dc_wdata_i = {16{8'hA5}};
      tick();
      chk("wb_mem_we", mem_we_o, 1);
      chk("wb_mem_wdata", mem_wdata_o, {16{8'hA5}});
      chk("wb_mem_addr", mem_addr_o, 20'h0ABC0);
      mem_ready_i = 1'b1;
      mem_rdata_i = {8{16'hDEAD}};
      tick();
      mem_ready_i = 1'b0;
      chk("wb_dc_valid", dc_valid_o, 1);
      chk("wb_ic_valid", ic_valid_o, 0);
      chk("wb_dc_data", dc_data_o, exp_dc);
      chk("wb_ic_data", ic_data_o, exp_ic);
      dc_req_i = 1'b0;
      dc_we_i  = 1'b0;
      tick();

      // Fresh reset so last-grant starts at IC, then three held ties
      rsn_i = 1'b0;
      tick();
      exp_ic = '0;
      exp_dc = '0;
      rsn_i = 1'b1;
      tick();
      ic_req_i   = 1'b1;
      ic_addr_i  = 20'h11111;
      dc_req_i   = 1'b1;
      dc_we_i    = 1'b0;
      dc_addr_i  = 20'h22222;
      dc_wdata_i = '0;
      for (int i = 0; i < 3; i++) begin
`ifdef MEM_ARB_RR_EN
         exp_win_dc = (i != 1);
`else
         exp_win_dc = 1'b1;
`endif
         tick();
         chk($sformatf("tie%0d_addr", i), mem_addr_o, exp_win_dc ? 20'h22220 : 20'h11110);
         line_v      = {4{32'h1000_0000 + 32'(i)}};
         mem_ready_i = 1'b1;
         mem_rdata_i = line_v;
         tick();
         mem_ready_i = 1'b0;
         if (exp_win_dc) exp_dc = line_v;
         else            exp_ic = line_v;
         chk($sformatf("tie%0d_dc_valid", i), dc_valid_o, exp_win_dc);
         chk($sformatf("tie%0d_ic_valid", i), ic_valid_o, !exp_win_dc);
         chk($sformatf("tie%0d_dc_data", i), dc_data_o, exp_dc);
         chk($sformatf("tie%0d_ic_data", i), ic_data_o, exp_ic);
         if (i == 2) begin
            ic_req_i = 1'b0;
            dc_req_i = 1'b0;
         end
         tick();
         chk($sformatf("tie%0d_idle", i), busy_o, 0);
      end

      // Zero-wait memory: valid two cycles after request, three-cycle turnaround
      mem_ready_i = 1'b1;
      line_v      = {4{32'hC0DE_0001}};
      mem_rdata_i = line_v;
      ic_req_i    = 1'b1;
      ic_addr_i   = 20'h00031;
      tick();
      chk("zw_busy_c1", mem_req_o, 1);
      tick();
      exp_ic = line_v;
      chk("zw_valid_c2", ic_valid_o, 1);
      chk("zw_data_c2", ic_data_o, exp_ic);
      tick();
      chk("zw_idle_c3", ic_valid_o, 0);
      chk("zw_idle_busy_c3", busy_o, 0);
      line_v      = {4{32'hC0DE_0002}};
      mem_rdata_i = line_v;
      tick();
      chk("zw_req_c4", mem_req_o, 1);
      tick();
      exp_ic = line_v;
      chk("zw_valid_c5", ic_valid_o, 1);
      chk("zw_data_c5", ic_data_o, exp_ic);
      ic_req_i = 1'b0;
      tick();
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      tick();
      chk("zw_end_busy", busy_o, 0);

      // Reset during BUSY aborts silently
      ic_req_i  = 1'b1;
      ic_addr_i = 20'h55555;
      tick();
      chk("ab_req_before", mem_req_o, 1);
      rsn_i = 1'b0;
      #1;
      exp_ic = '0;
      exp_dc = '0;
      chk("ab_req_now", mem_req_o, 0);
      chk("ab_busy_now", busy_o, 0);
      tick();
      chk("ab_ic_valid", ic_valid_o, 0);
      chk("ab_ic_data", ic_data_o, exp_ic);
      ic_req_i = 1'b0;
      tick();
      rsn_i = 1'b1;
      tick();
      chk("ab_post_valid", ic_valid_o, 0);
      ic_req_i  = 1'b1;
      ic_addr_i = 20'h7777F;
      tick();
      chk("ab_new_addr", mem_addr_o, 20'h77770);
      line_v      = {2{64'hFACE_B00C_1234_5678}};
      mem_ready_i = 1'b1;
      mem_rdata_i = line_v;
      tick();
      exp_ic      = line_v;
      mem_ready_i = 1'b0;
      chk("ab_new_valid", ic_valid_o, 1);
      chk("ab_new_data", ic_data_o, exp_ic);
      ic_req_i = 1'b0;
      tick();

      // Spurious ready in IDLE
      mem_ready_i = 1'b1;
      mem_rdata_i = '1;
      tick();
      chk("sp_ic_valid", ic_valid_o, 0);
      chk("sp_dc_valid", dc_valid_o, 0);
      chk("sp_busy", busy_o, 0);
      tick();
      chk("sp_ic_valid2", ic_valid_o, 0);
      chk("sp_dc_valid2", dc_valid_o, 0);
      chk("sp_ic_data", ic_data_o, exp_ic);
      chk("sp_dc_data", dc_data_o, exp_dc);
      mem_ready_i = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
